inside_query_drv: RTL and testbench
===================================

INSIDE_QUERY_DRV -- requirements
Module: inside_query_drv

Interface
REQ-001 Parameter: N, default 8, coordinate width; jammer x/y are N-bit signed, radius is N+1-bit, point x/y are N+2-bit signed.
REQ-002 Parameter: SETTLE, default 2, cycles each point is held on the checker inputs before o is sampled; legal range 1..15.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  pulse; accepted only in IDLE.
REQ-006 xJ, yJ  input  N each  jammer position, signed; captured on start.
REQ-007 rJ  input  N+1  jammer radius; captured on start.
REQ-008 x_min, y_min  input  N+2 each  grid origin, signed; captured on start.
REQ-009 step  input  N  grid pitch, unsigned; captured on start.
REQ-010 cols, rows  input  N each  grid size; 0 means 1.
REQ-011 g_input  output  2N+4  {xP, yP} to the in-range checker, xP in [2N+3:N+2].
REQ-012 e_input  output  3N+1  {xJ, yJ, rJ}, xJ in [3N:2N+1], yJ in [2N:N+1], rJ in [N:0].
REQ-013 o  input  1  checker result, combinational from g_input/e_input.
REQ-014 res_valid  output  1  result beat valid.
REQ-015 res_ready  input  1  downstream accept.
REQ-016 res_x, res_y, res_in  output  N+2, N+2, 1  point coordinates and sampled o.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle pulse at scan end.
REQ-019 hit_count  output  2N+1  number of points with o=1 in the current/last scan.

Function
REQ-020 FSM states IDLE, DRIVE, EMIT, FIN; IDLE->DRIVE on start; DRIVE->EMIT after SETTLE cycles; EMIT->DRIVE on accepted beat if points remain, else ->FIN; FIN->IDLE unconditionally (one cycle).
REQ-021 Scan order row-major: column index fastest; xP = x_min + col*step, yP = y_min + row*step, formed by step accumulation, modulo 2^(N+2) two's complement (wrap, no saturation).
REQ-022 g_input/e_input shall be registered and stable for the whole of DRIVE and EMIT for a given point.
REQ-023 o shall be sampled into res_in on the last DRIVE cycle; res_x/res_y equal the driven xP/yP.
REQ-024 res_valid high only in EMIT; res_x/res_y/res_in stable while res_valid=1 and res_ready=0.
REQ-025 Beat accepted when res_valid and res_ready both high; res_ready ignored outside EMIT.
REQ-026 hit_count cleared on start acceptance, incremented by 1 per sampled o=1 (at sample time), held after FIN until next start.
REQ-027 done asserted only in FIN; busy low in FIN's successor IDLE cycle.
REQ-028 start while busy=1 shall be ignored; captured parameters unchanged mid-scan.
REQ-029 Per-point latency with res_ready tied high: SETTLE+1 cycles; total scan = points*(SETTLE+1)+1 cycles after start.

Reset
REQ-030 rst_n=0 at a rising edge forces IDLE regardless of state, aborting any scan with no done pulse.
REQ-031 Reset values: g_input=0, e_input=0, res_valid=0, res_x=0, res_y=0, res_in=0, busy=0, done=0, hit_count=0.

Configuration
REQ-032 Macro INSIDE_DRV_HIT_FILTER_EN: when defined, a sampled o=0 skips EMIT (DRIVE advances to next point or FIN directly), so only hits are emitted; when undefined, every point emits one beat.

Verification
REQ-033 1x1 grid, origin (-72,-102), J=(-16,-111), r=236, ready=1 -> one beat res=(-72,-102,1), hit_count=1, done SETTLE+2 cycles after start.
REQ-034 1x1 grid at (151,-276), J=(-32,108), r=215 -> res_in=0, hit_count=0; with INSIDE_DRV_HIT_FILTER_EN no beat, done still pulses.
REQ-035 cols=3, rows=2, origin (-231,5), step=100, J=(109,-99), r=183 -> six beats in row-major order, x=-231,-131,-31, y=5,105; res_in/hit_count match behavioural distance model.
REQ-036 Wrap: x_min=500, step=20, cols=2, N=8 -> second xP=-504 (520 mod 1024 signed).
REQ-037 res_ready held low 10 cycles during EMIT -> res_* stable, no beat lost; start pulses during scan ignored.
REQ-038 rst_n low for one cycle mid-DRIVE -> next cycle all outputs at reset values, no done pulse; new start runs normally.

Source files
------------

// File: rtl/inside_query_drv_if.sv
// Result-beat stream from inside_query_drv to its consumer.
// The driver uses the master modport; the consumer uses slave and supplies res_ready.
interface inside_query_drv_if #(
  parameter int N = 8
);
  logic                res_valid;
  logic                res_ready;
  logic signed [N+1:0] res_x;
  logic signed [N+1:0] res_y;
  logic                res_in;

  modport master (output res_valid, res_x, res_y, res_in, input res_ready);
  modport slave  (input res_valid, res_x, res_y, res_in, output res_ready);
endinterface

// File: rtl/inside_query_drv.sv
// Scans a jammer against a rectangular grid of points through an external in-range checker.
// Each point's checker result is emitted as one result beat.
// Optional build macro INSIDE_DRV_HIT_FILTER_EN: only points with o=1 are emitted.
module inside_query_drv #(
  parameter int N      = 8,
  parameter int SETTLE = 2   // 1..15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic signed [N-1:0] xJ,
  input  logic signed [N-1:0] yJ,
  input  logic [N:0]          rJ,
  input  logic signed [N+1:0] x_min,
  input  logic signed [N+1:0] y_min,
  input  logic [N-1:0]        step,
  input  logic [N-1:0]        cols,
  input  logic [N-1:0]        rows,
  output logic [2*N+3:0]      g_input,
  output logic [3*N:0]        e_input,
  input  logic                o,
  output logic                busy,
  output logic                done,
  output logic [2*N:0]        hit_count,
  inside_query_drv_if.master  res
);

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, FIN} state_e;

  typedef struct packed {
    logic [3:0]   cnt;
    logic [N-1:0] xj;
    logic [N-1:0] yj;
    logic [N:0]   rj;
    logic [N-1:0] step;
    logic [N+1:0] x_min;
    logic [N-1:0] cols_last;
    logic [N-1:0] rows_last;
    logic [N-1:0] col;
    logic [N-1:0] row;
    logic [N+1:0] xp;
    logic [N+1:0] yp;
    logic [N+1:0] res_x;
    logic [N+1:0] res_y;
    logic         res_in;
    logic [2*N:0] hit;
  } dp_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_e       state_q, state_d;
  dp_t          dp_q, dp_d;
  logic         advance;
  logic         last_pt;
  logic [N+1:0] step_ext;

  assign step_ext = {2'b00, dp_q.step};
  assign last_pt  = (dp_q.col == dp_q.cols_last) && (dp_q.row == dp_q.rows_last);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case can infer a latch.
    state_d = state_q;
    dp_d    = dp_q;
    advance = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = DRIVE;
          dp_d.xj        = xJ;
          dp_d.yj        = yJ;
          dp_d.rj        = rJ;
          dp_d.step      = step;
          dp_d.x_min     = x_min;
          dp_d.cols_last = (cols == '0) ? '0 : cols - 1'b1;
          dp_d.rows_last = (rows == '0) ? '0 : rows - 1'b1;
          dp_d.col       = '0;
          dp_d.row       = '0;
          dp_d.xp        = x_min;
          dp_d.yp        = y_min;
          dp_d.hit       = '0;
          dp_d.cnt       = '0;
        end
      end
      DRIVE: begin
        if (dp_q.cnt == CNT_LAST) begin
          dp_d.res_x  = dp_q.xp;
          dp_d.res_y  = dp_q.yp;
          dp_d.res_in = o;
          if (o) dp_d.hit = dp_q.hit + 1'b1;
`ifdef INSIDE_DRV_HIT_FILTER_EN
          if (o) state_d = EMIT;
          else   advance = 1'b1;
`else
          state_d = EMIT;
`endif
        end else begin
          dp_d.cnt = dp_q.cnt + 1'b1;
        end
      end
      EMIT: begin
        if (res.res_ready) advance = 1'b1;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Row-major stepping by accumulation; coordinates wrap modulo 2^(N+2).
    if (advance) begin
      if (last_pt) begin
        state_d = FIN;
      end else begin
        state_d  = DRIVE;
        dp_d.cnt = '0;
        if (dp_q.col == dp_q.cols_last) begin
          dp_d.col = '0;
          dp_d.row = dp_q.row + 1'b1;
          dp_d.xp  = dp_q.x_min;
          dp_d.yp  = dp_q.yp + step_ext;
        end else begin
          dp_d.col = dp_q.col + 1'b1;
          dp_d.xp  = dp_q.xp + step_ext;
        end
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dp_q    <= '0;
    end else begin
      state_q <= state_d;
      dp_q    <= dp_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == FIN);
  assign hit_count     = dp_q.hit;
  assign g_input       = {dp_q.xp, dp_q.yp};
  assign e_input       = {dp_q.xj, dp_q.yj, dp_q.rj};
  assign res.res_valid = (state_q == EMIT);
  assign res.res_x     = dp_q.res_x;
  assign res.res_y     = dp_q.res_y;
  assign res.res_in    = dp_q.res_in;

endmodule

// File: tb/tb_inside_query_drv.sv
// Bench for inside_query_drv: behavioural in-range checker, result-beat scoreboard,
// table of grid scans, plus backpressure and mid-scan reset sequences.
module tb_inside_query_drv;

  localparam int N      = 8;
  localparam int SETTLE = 2;
  localparam int W      = N + 2;

  typedef struct {
    int x_min;
    int y_min;
    int step;
    int cols;
    int rows;
    int xj;
    int yj;
    int rj;
    int exp_hits;
  } vec_t;

  typedef struct {
    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic                in_r;
  } beat_t;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic signed [N-1:0] xJ    = '0;
  logic signed [N-1:0] yJ    = '0;
  logic [N:0]          rJ    = '0;
  logic signed [W-1:0] x_min = '0;
  logic signed [W-1:0] y_min = '0;
  logic [N-1:0]        step  = '0;
  logic [N-1:0]        cols  = '0;
  logic [N-1:0]        rows  = '0;
  logic                o;
  logic [2*N+3:0]      g_input;
  logic [3*N:0]        e_input;
  logic                busy;
  logic                done;
  logic [2*N:0]        hit_count;

  inside_query_drv_if #(.N(N)) rif ();

  inside_query_drv #(.N(N), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .xJ        (xJ),
    .yJ        (yJ),
    .rJ        (rJ),
    .x_min     (x_min),
    .y_min     (y_min),
    .step      (step),
    .cols      (cols),
    .rows      (rows),
    .g_input   (g_input),
    .e_input   (e_input),
    .o         (o),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count),
    .res       (rif)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  beat_t       exp_q[$];
  logic [3*N:0] exp_e = '0;

  function automatic logic in_range(input int xp, input int yp, input int xj, input int yj, input int r);
    longint dx, dy;
    dx = longint'(xp) - longint'(xj);
    dy = longint'(yp) - longint'(yj);
    return (dx * dx + dy * dy) <= (longint'(r) * longint'(r));
  endfunction

  // External in-range checker: purely combinational from the DUT's registered outputs.
  always_comb o = in_range(int'($signed(g_input[2*N+3:N+2])), int'($signed(g_input[N+1:0])),
                           int'($signed(e_input[3*N:2*N+1])), int'($signed(e_input[2*N:N+1])),
                           int'(e_input[N:0]));

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_g_input"},   g_input,       0);
    check({p, "_e_input"},   e_input,       0);
    check({p, "_res_valid"}, rif.res_valid, 0);
    check({p, "_res_x"},     rif.res_x,     0);
    check({p, "_res_y"},     rif.res_y,     0);
    check({p, "_res_in"},    rif.res_in,    0);
    check({p, "_busy"},      busy,          0);
    check({p, "_done"},      done,          0);
    check({p, "_hit_count"}, hit_count,     0);
  endtask

  function automatic void push_expected(input vec_t v, output int pts, output int hits);
    int nc, nr;
    logic signed [W-1:0] xw, yw;
    logic in_r;
    beat_t b;
    nc = (v.cols == 0) ? 1 : v.cols;
    nr = (v.rows == 0) ? 1 : v.rows;
    pts = 0;
    hits = 0;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < nc; c++) begin
        xw   = W'(v.x_min + c * v.step);
        yw   = W'(v.y_min + r * v.step);
        in_r = in_range(int'(xw), int'(yw), v.xj, v.yj, v.rj);
        b.x = xw;
        b.y = yw;
        b.in_r = in_r;
        pts++;
        if (in_r) hits++;
`ifdef INSIDE_DRV_HIT_FILTER_EN
        if (in_r) exp_q.push_back(b);
`else
        exp_q.push_back(b);
`endif
      end
    end
  endfunction

  task automatic drive_inputs(input vec_t v);
    xJ    = v.xj[N-1:0];
    yJ    = v.yj[N-1:0];
    rJ    = v.rj[N:0];
    x_min = v.x_min[W-1:0];
    y_min = v.y_min[W-1:0];
    step  = v.step[N-1:0];
    cols  = v.cols[N-1:0];
    rows  = v.rows[N-1:0];
    exp_e = {v.xj[N-1:0], v.yj[N-1:0], v.rj[N:0]};
  endtask

  // Scoreboard monitor: pops on every accepted beat and checks held beats under backpressure.
  logic  hold_v = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("stall_valid", rif.res_valid, 1);
        check("stall_x",     rif.res_x,     held.x);
        check("stall_y",     rif.res_y,     held.y);
        check("stall_in",    rif.res_in,    held.in_r);
      end
      hold_v = 1'b0;
      if (rif.res_valid) begin
        if (rif.res_ready) begin
          check("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            beat_t b;
            b = exp_q.pop_front();
            check("beat_x",       rif.res_x,  b.x);
            check("beat_y",       rif.res_y,  b.y);
            check("beat_in",      rif.res_in, b.in_r);
            check("beat_e_input", e_input,    exp_e);
          end
        end else begin
          hold_v    = 1'b1;
          held.x    = rif.res_x;
          held.y    = rif.res_y;
          held.in_r = rif.res_in;
        end
      end
    end
  end

  task automatic wait_done(output int e);
    e = 0;
    forever begin
      @(negedge clk);
      if (done || e >= 2000) break;
      @(posedge clk);
      #1;
      e++;
    end
  endtask

  task automatic run_scan(input vec_t v, input string tag);
    int pts, hits, e, exp_lat;
    push_expected(v, pts, hits);
    drive_inputs(v);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(e);
`ifdef INSIDE_DRV_HIT_FILTER_EN
    exp_lat = hits * (SETTLE + 1) + (pts - hits) * SETTLE;
`else
    exp_lat = pts * (SETTLE + 1);
`endif
    check({tag, "_done"},      done,      1);
    check({tag, "_latency"},   e,         exp_lat);
    check({tag, "_hits"},      hit_count, v.exp_hits);
    check({tag, "_busy_fin"},  busy,      1);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done,      0);
    check({tag, "_busy_idle"}, busy,      0);
    check({tag, "_hits_held"}, hit_count, v.exp_hits);
    check({tag, "_q_empty"},   exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];

  initial begin
    vec_t bp, rv;
    int pts, hits, e;

    vecs[0] = '{x_min:-72,  y_min:-102, step:1,   cols:1, rows:1, xj:-16,  yj:-111, rj:236, exp_hits:1};
    vecs[1] = '{x_min:151,  y_min:-276, step:1,   cols:1, rows:1, xj:-32,  yj:108,  rj:215, exp_hits:0};
    vecs[2] = '{x_min:-231, y_min:5,    step:100, cols:3, rows:2, xj:109,  yj:-99,  rj:183, exp_hits:1};
    vecs[3] = '{x_min:500,  y_min:0,    step:20,  cols:2, rows:1, xj:-100, yj:0,    rj:420, exp_hits:1};
    vecs[4] = '{x_min:0,    y_min:0,    step:7,   cols:0, rows:0, xj:0,    yj:0,    rj:0,   exp_hits:1};
    vecs[5] = '{x_min:-20,  y_min:-20,  step:15,  cols:4, rows:3, xj:0,    yj:0,    rj:25,  exp_hits:8};

    rif.res_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_scan(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: hold res_ready low for 10 cycles of EMIT while start is pulsed with other inputs.
    bp = '{x_min:10, y_min:20, step:30, cols:2, rows:1, xj:40, yj:20, rj:10, exp_hits:1};
    push_expected(bp, pts, hits);
    drive_inputs(bp);
    rif.res_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = 0;
    forever begin
      @(negedge clk);
      if (rif.res_valid || e >= 200) break;
      @(posedge clk);
      #1;
      e++;
    end
    check("bp_valid_seen", rif.res_valid, 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      start = 1'b1;
      xJ    = N'($urandom);
      rJ    = (N+1)'($urandom);
      x_min = W'($urandom);
      cols  = N'($urandom_range(2, 9));
      step  = N'($urandom);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    rif.res_ready = 1'b1;
    wait_done(e);
    check("bp_done",         done,         1);
    check("bp_hits",         hit_count,    bp.exp_hits);
    check("bp_e_input_kept", e_input,      exp_e);
    check("bp_q_empty",      exp_q.size(), 0);
    @(posedge clk);
    #1;

    // Reset asserted for one edge mid-DRIVE: outputs clear, no done, next scan runs normally.
    rv = '{x_min:30, y_min:40, step:5, cols:3, rows:1, xj:0, yj:0, rj:50, exp_hits:1};
    drive_inputs(rv);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", busy, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
    end
    @(posedge clk);
    #1;
    run_scan(rv, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
